// File: rtl/bf_result_streamer.sv
// Streams bellmanford Output Memory distances over valid/ready and counts reachable nodes.
// Optional build macro: SKIP_UNREACHABLE_EN (unreachable non-last entries are not presented).
module bf_result_streamer #(
  parameter int NUM_NODES = 8192,
  parameter int AW        = 13,
  parameter int DW        = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          Finish,
  input  logic          NegCycle,
  output logic [AW-1:0] OMAR,
  input  logic [DW-1:0] OMDR,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_index,
  output logic          out_unreach,
  output logic          out_neg,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   reach_count
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_NODES - 1);
  localparam logic [AW:0]   MAX_CNT  = (AW+1)'(NUM_NODES);
  localparam logic [DW-1:0] UNREACH  = '1;
  localparam logic [DW-1:0] NEG_WORD = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, FETCH, SEND, NEG, DONE} state_t;

  state_t        state, state_nxt;
  logic          finish_q, neg_q;
  logic          start_f, start_n, hs, idx_last;
  logic          begin_run, abort, skip;
  logic [AW-1:0] idx;

  assign start_f  = Finish & ~finish_q;
  assign start_n  = NegCycle & ~neg_q;
  assign hs       = out_valid & out_ready;
  assign idx_last = (idx == LAST_IDX);
  assign OMAR     = idx;
  assign busy     = (state != IDLE) && (state != DONE);
  assign done     = (state == DONE);

  always_comb begin
    state_nxt = state;
    begin_run = 1'b0;
    abort     = 1'b0;
    skip      = 1'b0;
`ifdef SKIP_UNREACHABLE_EN
    skip      = (OMDR == UNREACH) && !idx_last;
`endif
    case (state)
      IDLE, DONE: begin
        // negative cycle wins when both edges land together
        if (start_n) begin
          state_nxt = NEG;
          begin_run = 1'b1;
        end else if (start_f) begin
          state_nxt = FETCH;
          begin_run = 1'b1;
        end
      end
      FETCH: begin
        if (start_n) begin
          state_nxt = NEG;
          abort     = 1'b1;
        end else if (!skip) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (start_n) begin
          state_nxt = NEG;
          abort     = 1'b1;
        end else if (hs) begin
          state_nxt = out_last ? DONE : FETCH;
        end
      end
      NEG:     if (hs) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      finish_q    <= 1'b0;
      neg_q       <= 1'b0;
      idx         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_index   <= '0;
      out_unreach <= 1'b0;
      out_neg     <= 1'b0;
      out_last    <= 1'b0;
      reach_count <= '0;
    end else begin
      state    <= state_nxt;
      finish_q <= Finish;
      neg_q    <= NegCycle;
      if (begin_run) begin
        idx         <= '0;
        reach_count <= '0;
      end
      case (state)
        FETCH: begin
          if (abort) begin
            out_valid <= 1'b0;
          end else if (skip) begin
            idx <= idx + 1'b1;
          end else begin
            out_data    <= OMDR;
            out_index   <= idx;
            out_unreach <= (OMDR == UNREACH);
            out_neg     <= 1'b0;
            out_last    <= idx_last;
            out_valid   <= 1'b1;
          end
        end
        SEND: begin
          // an abort drops the pending word without counting it
          if (abort) begin
            out_valid <= 1'b0;
          end else if (hs) begin
            out_valid <= 1'b0;
            if (!out_unreach && (reach_count < MAX_CNT))
              reach_count <= reach_count + 1'b1;
            if (!out_last)
              idx <= idx + 1'b1;
          end
        end
        NEG: begin
          if (hs) begin
            out_valid <= 1'b0;
          end else begin
            out_valid   <= 1'b1;
            out_data    <= NEG_WORD;
            out_index   <= '0;
            out_unreach <= 1'b0;
            out_neg     <= 1'b1;
            out_last    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_result_streamer.sv
// Randomized self-checking bench for bf_result_streamer (4-node memory, AW=2 so 2**AW entries).
module tb_bf_result_streamer;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  index;
    logic        unreach;
    logic        neg;
    logic        last;
  } word_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        Finish = 1'b0;
  logic        NegCycle = 1'b0;
  logic [1:0]  OMAR;
  logic [15:0] OMDR;
  logic        out_valid, out_ready = 1'b0;
  logic [15:0] out_data;
  logic [1:0]  out_index;
  logic        out_unreach, out_neg, out_last, busy, done;
  logic [2:0]  reach_count;

  logic [15:0] mem [4];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;
  assign OMDR = mem[OMAR];

  bf_result_streamer #(.NUM_NODES(4), .AW(2), .DW(16)) dut (
    .clock(clock), .reset(reset), .Finish(Finish), .NegCycle(NegCycle),
    .OMAR(OMAR), .OMDR(OMDR), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_unreach(out_unreach),
    .out_neg(out_neg), .out_last(out_last), .busy(busy), .done(done),
    .reach_count(reach_count)
  );

  function automatic word_t cur_word();
    word_t w;
    w.data = out_data; w.index = out_index; w.unreach = out_unreach;
    w.neg = out_neg; w.last = out_last;
    return w;
  endfunction

  task automatic test_reset(input string name);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({out_valid, out_data, out_index, out_unreach, out_neg, out_last, busy, done, reach_count, OMAR} !== '0) begin
      errors++;
      $display("FAIL %s: outputs got v=%b d=%h i=%0d u=%b n=%b l=%b busy=%b done=%b rc=%0d omar=%0d, want all 0",
               name, out_valid, out_data, out_index, out_unreach, out_neg, out_last, busy, done, reach_count, OMAR);
    end
    reset = 1'b0;
  endtask

  // Pulse Finish, drain the stream under a ready pattern, compare with the model.
  // mode 0: ready always, 1: toggling, 2: random. blip re-pulses Finish mid-stream.
  task automatic test_walk(input string name, input int mode, input bit blip, input bit chk_lat);
    word_t exp_q[$], got[$];
    word_t cur, prev, w;
    int rc = 0, cyc = 0;
    bit stalled = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem[i] != 16'hFFFF) rc++;
`ifdef SKIP_UNREACHABLE_EN
      if (mem[i] == 16'hFFFF && i != 3) continue;
`endif
      w.data = mem[i]; w.index = i[1:0]; w.unreach = (mem[i] == 16'hFFFF);
      w.neg = 1'b0; w.last = (i == 3);
      exp_q.push_back(w);
    end
    out_ready = 1'b0;
    @(negedge clock) Finish = 1'b1;
    @(negedge clock) Finish = 1'b0;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s start: busy=%b valid=%b, want busy=1 valid=0", name, busy, out_valid);
    end
    if (chk_lat) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || out_index !== 2'd0) begin
        errors++;
        $display("FAIL %s latency: valid=%b idx=%0d two cycles after Finish, want 1/0", name, out_valid, out_index);
      end
    end
    while (!done && cyc < 80) begin
      @(negedge clock);
      cyc++;
      cur = cur_word();
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || cur !== prev) begin
          errors++;
          $display("FAIL %s stall: valid=%b word=%h, want 1 and held %h", name, out_valid, cur, prev);
        end
      end
      if (blip) Finish = (cyc == 2);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 1);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) got.push_back(cur);
      stalled = out_valid && !out_ready;
      prev = cur;
    end
    Finish = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: done=0 after %0d cycles, want done=1", name, cyc);
    end
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s count: got %0d words, want %0d", name, got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s word%0d: got %h, want %h", name, i, got[i], exp_q[i]);
      end
    end
    repeat (3) @(negedge clock);
    checks++;
    if (reach_count !== 3'(rc) || done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s end: rc=%0d done=%b busy=%b valid=%b, want rc=%0d done=1 busy=0 valid=0",
               name, reach_count, done, busy, out_valid, rc);
    end
  endtask

  task automatic test_neg_with_finish(input string name);
    int n = 0, seen = 0;
    out_ready = 1'b0;
    @(negedge clock); Finish = 1'b1; NegCycle = 1'b1;
    @(negedge clock); Finish = 1'b0; NegCycle = 1'b0;
    while (!out_valid && n < 10) begin @(negedge clock); n++; end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h8000 || out_neg !== 1'b1 || out_last !== 1'b1 ||
        out_index !== 2'd0 || out_unreach !== 1'b0) begin
      errors++;
      $display("FAIL %s word: v=%b d=%h neg=%b last=%b idx=%0d u=%b, want 1/8000/1/1/0/0",
               name, out_valid, out_data, out_neg, out_last, out_index, out_unreach);
    end
    out_ready = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin @(negedge clock); if (out_valid) seen++; end
    checks++;
    if (seen != 0 || done !== 1'b1 || reach_count !== 3'd0) begin
      errors++;
      $display("FAIL %s end: extra=%0d done=%b rc=%0d, want 0/1/0", name, seen, done, reach_count);
    end
  endtask

  task automatic test_neg_abort(input string name);
    int n = 0;
    mem = '{16'h0000, 16'h0005, 16'hFFFF, 16'h000C};
    out_ready = 1'b0;
    @(negedge clock) Finish = 1'b1;
    @(negedge clock) Finish = 1'b0;
    @(negedge clock) out_ready = 1'b1;
    @(negedge clock) out_ready = 1'b0;
    while (!(out_valid && out_index == 2'd1) && n < 10) begin @(negedge clock); n++; end
    checks++;
    if (out_valid !== 1'b1 || out_index !== 2'd1) begin
      errors++;
      $display("FAIL %s reach idx1: valid=%b idx=%0d, want 1/1", name, out_valid, out_index);
    end
    NegCycle = 1'b1;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s drop: valid=%b busy=%b, want 0/1", name, out_valid, busy);
    end
    NegCycle = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 10) begin @(negedge clock); n++; end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h8000 || out_neg !== 1'b1 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL %s neg word: v=%b d=%h neg=%b last=%b, want 1/8000/1/1",
               name, out_valid, out_data, out_neg, out_last);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b1 || reach_count !== 3'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s end: done=%b rc=%0d valid=%b, want 1/1/0", name, done, reach_count, out_valid);
    end
  endtask

  task automatic test_reset_mid(input string name);
    mem = '{16'h0000, 16'h0005, 16'hFFFF, 16'h000C};
    out_ready = 1'b0;
    @(negedge clock) Finish = 1'b1;
    @(negedge clock) Finish = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({out_valid, out_data, out_index, out_unreach, out_neg, out_last, busy, done, reach_count, OMAR} !== '0) begin
      errors++;
      $display("FAIL %s: v=%b d=%h i=%0d busy=%b done=%b rc=%0d, want all 0",
               name, out_valid, out_data, out_index, busy, done, reach_count);
    end
    reset = 1'b0;
    test_walk("restart", 0, 1'b0, 1'b1);
  endtask

  task automatic test_random(input string name);
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 4; i++)
        mem[i] = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
      test_walk(name, 2, it[0], 1'b0);
    end
    mem = '{16'h0001, 16'h0002, 16'h0003, 16'hFFFE};
    test_walk("all_reach", 2, 1'b1, 1'b0);
  endtask

  initial begin
    mem = '{16'h0000, 16'h0005, 16'hFFFF, 16'h000C};
    test_reset("reset");
    test_walk("basic", 0, 1'b0, 1'b1);
    test_walk("toggle", 1, 1'b0, 1'b0);
    test_neg_with_finish("neg_finish");
    test_neg_abort("neg_abort");
    test_reset_mid("reset_mid");
    mem = '{16'hFFFF, 16'h0007, 16'hFFFF, 16'hFFFF};
    test_walk("sparse", 2, 1'b0, 1'b0);
    test_random("random");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
